// File: rtl/sm_calc_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sm_calc_if
// Brief  : Operand entry, add-unit and result bundle for the sm_calc_ctrl sequencer.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface sm_calc_if #(
    parameter int CNT_W = 8
);
    logic             clear;
    logic             in_valid;
    logic [2:0]       in_data;
    logic             op_sub;
    logic [2:0]       add_num1;
    logic [2:0]       add_num2;
    logic [3:0]       add_result;
    logic             busy;
    logic             res_valid;
    logic [3:0]       res_value;
    logic             res_zero;
    logic             overrun;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  clear, in_valid, in_data, op_sub, add_result,
        output add_num1, add_num2, busy, res_valid, res_value, res_zero, overrun, op_count
    );

    modport master (
        output clear, in_valid, in_data, op_sub, add_result,
        input  add_num1, add_num2, busy, res_valid, res_value, res_zero, overrun, op_count
    );
endinterface
`default_nettype wire

// File: rtl/sm_calc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sm_calc_ctrl
// Brief  : Two-operand sequencer for a 3-bit sign-magnitude add unit.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module sm_calc_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    sm_calc_if.slave    bus
);

    localparam int                c_SW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_SW-1:0]   c_LAST = c_SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPA  = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    state_t           r_state;
    logic [c_SW-1:0]  r_cnt;

    logic [2:0] w_norm;
    logic [2:0] w_opb;
    logic [3:0] w_res;

    // -0 is folded to +0 so zero never carries a sign into the add unit
    assign w_norm = (bus.in_data[1:0] == 2'b00) ? 3'b000 : bus.in_data;
    assign w_opb  = {(w_norm[2] ^ bus.op_sub) & (|w_norm[1:0]), w_norm[1:0]};
    assign w_res  = {bus.add_result[3] & (|bus.add_result[2:0]), bus.add_result[2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            bus.add_num1  <= 3'b000;
            bus.add_num2  <= 3'b000;
            bus.busy      <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_value <= 4'b0000;
            bus.res_zero  <= 1'b0;
            bus.overrun   <= 1'b0;
            bus.op_count  <= '0;
        end else if (bus.clear) begin
            r_state       <= S_IDLE;
            bus.busy      <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        bus.add_num1 <= w_norm;
                        r_state      <= S_OPA;
                    end
                end
                S_OPA: begin
                    if (bus.in_valid) begin
                        bus.add_num2 <= w_opb;
                        r_cnt        <= '0;
                        bus.busy     <= 1'b1;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // strobes here, including on the capture edge, are dropped
                    if (bus.in_valid) begin
                        bus.overrun <= 1'b1;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        bus.res_value <= w_res;
                        bus.res_zero  <= ~(|bus.add_result[2:0]);
                        bus.res_valid <= 1'b1;
                        bus.op_count  <= bus.op_count + 1'b1;
                        bus.busy      <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sm_calc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_sm_calc_ctrl
// Brief  : Directed scoreboard bench for sm_calc_ctrl with a delayed add-unit model.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_sm_calc_ctrl;

    localparam int c_SETTLE = 2;

    typedef struct packed {
        logic [3:0] val;
        logic       zero;
        logic [7:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst_n;
    int         total;
    int         bad;
    exp_t       q[$];
    logic [7:0] exp_count;
    logic [3:0] w_sum;

    sm_calc_if #(.CNT_W(8)) bus ();

    sm_calc_ctrl #(
        .SETTLE_CYCLES (c_SETTLE),
        .CNT_W         (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #40 clk = ~clk;

    function automatic logic [3:0] add_unit(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] ma;
        logic [2:0] mb;
        ma = {1'b0, a[1:0]};
        mb = {1'b0, b[1:0]};
        if (a[2] == b[2]) return {a[2], ma + mb};
        if (ma >= mb)     return {a[2], ma - mb};
        return {b[2], mb - ma};
    endfunction

    // add unit settles 100 ns after its operands move
    always_comb w_sum = add_unit(bus.add_num1, bus.add_num2);
    assign #100 bus.add_result = w_sum;

    function automatic logic [2:0] m_norm(input logic [2:0] x);
        return (x[1:0] == 2'b00) ? 3'b000 : x;
    endfunction

    function automatic logic [2:0] m_opb(input logic [2:0] x, input logic sub);
        logic [2:0] n;
        n = m_norm(x);
        if (n[1:0] == 2'b00) return 3'b000;
        return {n[2] ^ sub, n[1:0]};
    endfunction

    function automatic logic [3:0] m_sum(input logic [2:0] a, input logic [2:0] b);
        int va;
        int vb;
        int s;
        va = a[2] ? -int'(a[1:0]) : int'(a[1:0]);
        vb = b[2] ? -int'(b[1:0]) : int'(b[1:0]);
        s  = va + vb;
        if (s < 0) return {1'b1, 3'(-s)};
        return {1'b0, 3'(s)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_ab(input logic [2:0] a, input logic [2:0] b, input logic sub);
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = a;
        bus.op_sub   = 1'b0;
        tick();
        chk("num1", 32'(bus.add_num1), 32'(m_norm(a)));
        bus.in_data = b;
        bus.op_sub  = sub;
        tick();
        bus.in_valid = 1'b0;
        bus.op_sub   = 1'b0;
        chk("num2", 32'(bus.add_num2), 32'(m_opb(b, sub)));
        chk("busy_exec", 32'(bus.busy), 32'd1);
    endtask

    task automatic do_op(input logic [2:0] a, input logic [2:0] b, input logic sub);
        int   n;
        exp_t e;
        logic [3:0] r;
        start_ab(a, b, sub);
        r = m_sum(m_norm(a), m_opb(b, sub));
        exp_count = exp_count + 8'd1;
        e.val  = r;
        e.zero = (r[2:0] == 3'b000);
        e.cnt  = exp_count;
        q.push_back(e);
        n = 0;
        while (n < 10) begin
            tick();
            n++;
            if (bus.res_valid === 1'b1) break;
        end
        chk("latency", 32'(n), 32'(c_SETTLE));
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("res_value", 32'(bus.res_value), 32'(e.val));
            chk("res_zero",  32'(bus.res_zero),  32'(e.zero));
            chk("op_count",  32'(bus.op_count),  32'(e.cnt));
        end
        chk("hold1", 32'(bus.add_num1), 32'(m_norm(a)));
        chk("hold2", 32'(bus.add_num2), 32'(m_opb(b, sub)));
        chk("busy_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b0;
        total        = 0;
        bad          = 0;
        exp_count    = 8'd0;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 3'b000;
        bus.op_sub   = 1'b0;

        tick();
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_value", 32'(bus.res_value), 32'd0);
        chk("rst_count", 32'(bus.op_count),  32'd0);
        chk("rst_ovr",   32'(bus.overrun),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: +3 + +2
        do_op(3'b011, 3'b010, 1'b0);
        chk("t1_num2",  32'(bus.add_num2),  32'h2);
        chk("t1_value", 32'(bus.res_value), 32'h5);
        chk("t1_count", 32'(bus.op_count),  32'd1);

        // T2: +1 - +1
        do_op(3'b001, 3'b001, 1'b1);
        chk("t2_num2",  32'(bus.add_num2),  32'h5);
        chk("t2_value", 32'(bus.res_value), 32'h0);
        chk("t2_zero",  32'(bus.res_zero),  32'd1);

        // T3: -2 + +1
        do_op(3'b110, 3'b001, 1'b0);
        chk("t3_value", 32'(bus.res_value), 32'h9);
        chk("t3_count", 32'(bus.op_count),  32'd3);

        // T4: strobes during EXEC and on the capture edge
        start_ab(3'b001, 3'b010, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 3'b011;
        tick();
        chk("t4_ovr_set",  32'(bus.overrun),   32'd1);
        chk("t4_novalid",  32'(bus.res_valid), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        exp_count = exp_count + 8'd1;
        chk("t4_valid",    32'(bus.res_valid), 32'd1);
        chk("t4_value",    32'(bus.res_value), 32'h3);
        chk("t4_num1",     32'(bus.add_num1),  32'h1);
        chk("t4_num2",     32'(bus.add_num2),  32'h2);
        chk("t4_count",    32'(bus.op_count),  32'(exp_count));
        do_op(3'b010, 3'b010, 1'b1);
        chk("t4_sticky",   32'(bus.overrun),   32'd1);
        tick();
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 3'b001;
        tick();
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        chk("t4_clr_ovr",  32'(bus.overrun),   32'd0);
        chk("t4_clr_val",  32'(bus.res_value), 32'h0);
        chk("t4_clr_zero", 32'(bus.res_zero),  32'd1);
        chk("t4_clr_cnt",  32'(bus.op_count),  32'(exp_count));
        // clear mid-EXEC aborts without a completion
        start_ab(3'b011, 3'b011, 1'b0);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("t4_abort_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_abort_valid", 32'(bus.res_valid), 32'd0);
        end
        chk("t4_abort_cnt", 32'(bus.op_count), 32'(exp_count));
        do_op(3'b111, 3'b001, 1'b1);

        // T5: asynchronous reset one cycle into EXEC
        start_ab(3'b011, 3'b011, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        exp_count = 8'd0;
        chk("t5_busy",  32'(bus.busy),      32'd0);
        chk("t5_num1",  32'(bus.add_num1),  32'd0);
        chk("t5_num2",  32'(bus.add_num2),  32'd0);
        chk("t5_value", 32'(bus.res_value), 32'd0);
        chk("t5_zero",  32'(bus.res_zero),  32'd0);
        chk("t5_ovr",   32'(bus.overrun),   32'd0);
        chk("t5_count", 32'(bus.op_count),  32'd0);
        chk("t5_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_novalid", 32'(bus.res_valid), 32'd0);
        end

        // T6: run the counter up to 255, then -0 + -0 wraps it
        for (int i = 0; i < 255; i++) begin
            do_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        chk("t6_pre", 32'(bus.op_count), 32'd255);
        do_op(3'b100, 3'b100, 1'b0);
        chk("t6_num1",  32'(bus.add_num1),  32'd0);
        chk("t6_num2",  32'(bus.add_num2),  32'd0);
        chk("t6_value", 32'(bus.res_value), 32'd0);
        chk("t6_zero",  32'(bus.res_zero),  32'd1);
        chk("t6_wrap",  32'(bus.op_count),  32'd0);
        chk("q_empty",  32'(q.size()),      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
